// File: rtl/serial_word_assembler.sv
// Serial-in / parallel-out word assembler with a two-entry output buffer
// (output register + holding register) and a sticky drop flag.
module serial_word_assembler #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overflow
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             out_full;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic             accept;
  logic             done;
  logic             xfer;
  logic [WIDTH-1:0] shifted;

  assign accept  = sin_valid && !clear;
  assign done    = accept && (cnt == CW'(WIDTH - 1));
  assign xfer    = out_full && word_ready;
  // Shift register plus the incoming bit; on the last bit this is the word.
  assign shifted = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= done ? '0 : shifted;
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

  // Hold is only ever occupied while the output register is, which keeps
  // words leaving in completion order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg   <= '0;
      hold_reg  <= '0;
      out_full  <= 1'b0;
      hold_full <= 1'b0;
      ovf       <= 1'b0;
    end else if (!out_full) begin
      if (done) begin
        out_reg  <= shifted;
        out_full <= 1'b1;
      end
    end else if (!hold_full) begin
      if (done && xfer) begin
        out_reg <= shifted;
      end else if (done) begin
        hold_reg  <= shifted;
        hold_full <= 1'b1;
      end else if (xfer) begin
        out_full <= 1'b0;
      end
    end else begin
      if (xfer) begin
        out_reg <= hold_reg;
        if (done) hold_reg  <= shifted;
        else      hold_full <= 1'b0;
      end else if (done) begin
        ovf <= 1'b1;
      end
    end
  end

  assign word_out   = out_reg;
  assign word_valid = out_full;
  assign bit_cnt    = cnt;
  assign overflow   = ovf;

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Serial-in, parallel-out front end that collects a 1-bit stream into WIDTH-bit words.
- Sits directly upstream of the fixed bit-rotate stage and feeds its `a` input.
- The serial source cannot be stalled, so a two-entry buffer (output register plus holding register) absorbs backpressure from the downstream valid/ready consumer.
- Sticky overflow flag reports dropped words.

Parameters:
- WIDTH, 6: word width; matches the rotate stage input width.
- MSB_FIRST, 1: 1 = first serial bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this clock edge.
- clear  input  1  synchronous abort of the partially assembled word.
- word_out  output  WIDTH  assembled word; drives the rotate stage input.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  downstream accepts word_out this cycle.
- bit_cnt  output  ceil(log2(WIDTH+1))  bits of the current partial word, range 0..WIDTH-1.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all state clears. Shift register=0, bit_cnt=0, out_full=0, hold_full=0, word_out=0, word_valid=0, overflow=0. Reset mid-word discards the partial word and both buffered words.
- Assembly:
  - Each edge with sin_valid=1 and clear=0 shifts sin into the shift register and increments bit_cnt.
  - MSB_FIRST=1: shift left, new bit enters bit 0. MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
- Completion: the edge accepting a bit while bit_cnt==WIDTH-1 forms the completed word (shift register plus the new bit) and wraps bit_cnt to 0. The next bit starts a new word with no gap cycle.
- clear: zeroes the shift register and bit_cnt only; buffered words are untouched. If clear and sin_valid are both high, clear wins and the bit is discarded.
- Latency: if the output register is empty, word_valid rises the cycle after the last bit edge, with word_out equal to the completed word.
- Output handshake: a transfer occurs when word_valid && word_ready. While word_valid=1 and word_ready=0, word_out is held stable.
- Buffer moves on each edge, where C = word completed and T = output transfer:
  - Output empty: C loads the output register. Hold is empty by invariant.
  - Output full, hold empty: C and not T → C goes to hold. C and T → C goes to output, word_valid stays 1. T only → output empties.
  - Output full, hold full: T → hold moves to output. If C is also set, C goes to hold and no drop occurs. C without T → the new word is dropped, overflow sets, and the buffered words are unchanged.
- Ordering: words leave strictly in completion order. Hold is never full while the output register is empty.
- overflow: cleared only by rst_n. clear does not affect it.
- word_valid equals out_full, a registered output.
- word_ready is ignored while word_valid=0.

Test Plan:
- Reset, then 6 bits 1,0,1,1,0,0 with sin_valid=1, MSB_FIRST=1, word_ready=1 → word_out=6'b101100 and word_valid=1 for exactly one cycle, starting one cycle after the sixth bit; bit_cnt sequence 1..5 then 0.
- Same stream with MSB_FIRST=0 → word_out=6'b001101.
- word_ready=0, send 12 bits forming 6'h2A then 6'h15 → word_valid=1 holding 6'h2A. Raise word_ready for 2 cycles → 6'h2A then 6'h15 are accepted; word_valid=0 afterwards; overflow=0.
- word_ready=0, send three words 6'h01, 6'h02, 6'h03 → overflow=1 after the third completes. Draining yields only 6'h01, 6'h02. overflow stays 1 until rst_n=0.
- Send 3 bits, pulse clear together with sin_valid=1, then send 6'h3F → only 6'h3F is output; bit_cnt=0 after clear.
- Output and hold full with word_ready=1 on the same edge a third word completes → no overflow; the three words emerge in order over consecutive accepted cycles.
- rst_n=0 for one cycle with 4 bits pending and both buffers full → all outputs 0 on the next cycle. A following fresh 6-bit word assembles correctly.
